// File: rtl/popcount_pkg.sv
`default_nettype none
// ============================================================================
// Module      : popcount_pkg
// Description : Shared types and default sizing for the popcount window
//               accumulator: default WIDTH/WINDOW, derived field widths,
//               the packed per-window result record and the output
//               register state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package popcount_pkg;

    // Default configuration of the upstream popcounter and window length.
    localparam int DEF_WIDTH  = 128;
    localparam int DEF_WINDOW = 16;

    // Field widths derived from the defaults.
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH) + 1;
    localparam int DEF_LEN_W = $clog2(DEF_WINDOW + 1);
    localparam int DEF_SUM_W = $clog2(DEF_WIDTH * DEF_WINDOW + 1);

    // One completed window at the default sizing. Field order matches the
    // packing used by the accumulator: {sum, len, max}.
    typedef struct packed {
        logic [DEF_SUM_W-1:0] sum;
        logic [DEF_LEN_W-1:0] len;
        logic [DEF_CNT_W-1:0] max;
    } window_result_t;

    // Occupancy of the one-entry output register.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

endpackage : popcount_pkg
`default_nettype wire

// File: rtl/popcount_window_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : popcount_window_out_reg
// Description : One-entry valid/ready holding register for completed window
//               results, with drop detection when a new result arrives while
//               an unaccepted one is still held.
// Ports       : clk_i       - clock
//               rst_ni      - reset, asynchronous assert, active-low
//               complete_i  - a window closed this cycle; result_i is valid
//               result_i    - packed result of the closing window
//               ready_i     - downstream accepts result_o when valid_o=1
//               result_o    - held result, stable while valid_o && !ready_i
//               valid_o     - result_o holds an unaccepted result
//               drop_o      - one-cycle pulse: a result was discarded
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_window_out_reg
    import popcount_pkg::*;
#(
    parameter int RES_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             complete_i,
    input  logic [RES_W-1:0] result_i,
    input  logic             ready_i,
    output logic [RES_W-1:0] result_o,
    output logic             valid_o,
    output logic             drop_o
);

    out_state_e       state_q, state_d;
    logic [RES_W-1:0] result_q, result_d;
    logic             drop_q, drop_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= EMPTY;
            result_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        drop_d   = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (complete_i) begin
                    state_d  = FULL;
                    result_d = result_i;
                end
            end
            FULL: begin
                if (complete_i && ready_i) begin
                    // The held result leaves on this edge, so the new one
                    // can take its place without loss.
                    result_d = result_i;
                end else if (complete_i) begin
                    // Keep the older result; the new one is lost.
                    drop_d = 1'b1;
                end else if (ready_i) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    assign result_o = result_q;
    assign valid_o  = (state_q == FULL);
    assign drop_o   = drop_q;

endmodule : popcount_window_out_reg
`default_nettype wire

// File: rtl/popcount_window_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : popcount_window_accumulator
// Description : Sums popcount samples over windows of WINDOW valid samples
//               (or shorter, when closed early by flush_i) and offers the
//               per-window sum, sample count and peak on a one-entry
//               valid/ready output register.
// Options     : POPCNT_WINDOW_MAX_EN - when defined, max_o carries the
//               per-window peak sample; otherwise max tracking is absent and
//               max_o is tied to 0.
// Ports       : clk_i       - clock
//               arst_ni     - asynchronous active-low reset (released
//                             synchronously inside this block)
//               data_i      - popcount sample, 0..WIDTH
//               data_val_i  - sample valid; always absorbed
//               flush_i     - close the current window early
//               sum_o       - sum of samples in the completed window
//               len_o       - number of samples in the completed window
//               max_o       - largest sample in the completed window
//               sum_val_o   - result valid
//               sum_ready_i - result accepted when sum_val_o && sum_ready_i
//               drop_o      - one-cycle pulse: completed window was lost
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_window_accumulator
    import popcount_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int WINDOW = DEF_WINDOW,
    localparam int CNT_W  = $clog2(WIDTH) + 1,
    localparam int LEN_W  = $clog2(WINDOW + 1),
    localparam int SUM_W  = $clog2(WIDTH * WINDOW + 1)
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic [CNT_W-1:0] data_i,
    input  logic             data_val_i,
    input  logic             flush_i,
    output logic [SUM_W-1:0] sum_o,
    output logic [LEN_W-1:0] len_o,
    output logic [CNT_W-1:0] max_o,
    output logic             sum_val_o,
    input  logic             sum_ready_i,
    output logic             drop_o
);

    localparam int RES_W = SUM_W + LEN_W + CNT_W;

    // ------------------------------------------------------------------
    // Reset: assert immediately, release only after two clean clock edges
    // so every flop below leaves reset on the same edge.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // Accumulate side
    // ------------------------------------------------------------------
    logic [SUM_W-1:0] acc_sum_q, acc_sum_d;
    logic [LEN_W-1:0] acc_len_q, acc_len_d;
    logic [SUM_W-1:0] sum_incl;
    logic [LEN_W-1:0] len_incl;
    logic [CNT_W-1:0] max_incl;
    logic             complete;

    // Running totals including this cycle's sample, if any. These are what
    // a window closing this cycle reports.
    assign sum_incl = data_val_i ? (acc_sum_q + SUM_W'(data_i)) : acc_sum_q;
    assign len_incl = data_val_i ? (acc_len_q + LEN_W'(1)) : acc_len_q;

    // A flush with nothing accumulated and no sample is a no-op.
    assign complete = (data_val_i && (len_incl == LEN_W'(WINDOW)))
                   || (flush_i && (data_val_i || (acc_len_q != '0)));

    // On close the accumulators restart from zero, so the closing sample
    // is never counted twice.
    always_comb begin
        acc_sum_d = acc_sum_q;
        acc_len_d = acc_len_q;
        if (complete) begin
            acc_sum_d = '0;
            acc_len_d = '0;
        end else if (data_val_i) begin
            acc_sum_d = sum_incl;
            acc_len_d = len_incl;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum_q <= '0;
            acc_len_q <= '0;
        end else begin
            acc_sum_q <= acc_sum_d;
            acc_len_q <= acc_len_d;
        end
    end

`ifdef POPCNT_WINDOW_MAX_EN
    logic [CNT_W-1:0] acc_max_q, acc_max_d;

    assign max_incl = (data_val_i && (data_i > acc_max_q)) ? data_i : acc_max_q;

    always_comb begin
        acc_max_d = acc_max_q;
        if (complete) begin
            acc_max_d = '0;
        end else if (data_val_i) begin
            acc_max_d = max_incl;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            acc_max_q <= '0;
        end else begin
            acc_max_q <= acc_max_d;
        end
    end
`else
    assign max_incl = '0;
`endif

    // ------------------------------------------------------------------
    // Output side
    // ------------------------------------------------------------------
    logic [RES_W-1:0] result_in;
    logic [RES_W-1:0] result_out;

    assign result_in = {sum_incl, len_incl, max_incl};

    popcount_window_out_reg #(
        .RES_W (RES_W)
    ) u_out_reg (
        .clk_i      (clk_i),
        .rst_ni     (rst_n),
        .complete_i (complete),
        .result_i   (result_in),
        .ready_i    (sum_ready_i),
        .result_o   (result_out),
        .valid_o    (sum_val_o),
        .drop_o     (drop_o)
    );

    assign sum_o = result_out[RES_W-1 -: SUM_W];
    assign len_o = result_out[CNT_W +: LEN_W];
    assign max_o = result_out[CNT_W-1:0];

endmodule : popcount_window_accumulator
`default_nettype wire

// File: tb/tb_popcount_window_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_popcount_window_accumulator
// Description : Directed self-checking bench for popcount_window_accumulator
//               with WIDTH=128, WINDOW=4. Expected max_o follows the
//               POPCNT_WINDOW_MAX_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_popcount_window_accumulator;

    localparam int WIDTH  = 128;
    localparam int WINDOW = 4;
    localparam int CNT_W  = $clog2(WIDTH) + 1;
    localparam int LEN_W  = $clog2(WINDOW + 1);
    localparam int SUM_W  = $clog2(WIDTH * WINDOW + 1);

`ifdef POPCNT_WINDOW_MAX_EN
    localparam bit MAX_EN = 1'b1;
`else
    localparam bit MAX_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             arst_n = 1'b0;
    logic [CNT_W-1:0] data = '0;
    logic             data_val = 1'b0;
    logic             flush = 1'b0;
    logic             ready = 1'b0;
    logic [SUM_W-1:0] sum;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] max;
    logic             sum_val;
    logic             drop;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    popcount_window_accumulator #(
        .WIDTH  (WIDTH),
        .WINDOW (WINDOW)
    ) dut (
        .clk_i       (clk),
        .arst_ni     (arst_n),
        .data_i      (data),
        .data_val_i  (data_val),
        .flush_i     (flush),
        .sum_o       (sum),
        .len_o       (len),
        .max_o       (max),
        .sum_val_o   (sum_val),
        .sum_ready_i (ready),
        .drop_o      (drop)
    );

    // Advance one clock; inputs set before the call are captured on the edge
    // and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int v, input bit fl);
        data     = CNT_W'(v);
        data_val = 1'b1;
        flush    = fl;
        tick();
        data_val = 1'b0;
        flush    = 1'b0;
        data     = '0;
    endtask

    task automatic test_reset();
        #3;
        n_vec++; if (sum_val !== 1'b0) begin n_err++; $display("FAIL reset_val got %0b want 0", sum_val); end
        n_vec++; if (sum !== '0 || len !== '0 || max !== '0) begin n_err++; $display("FAIL reset_data got sum=%0d len=%0d max=%0d want 0/0/0", sum, len, max); end
        n_vec++; if (drop !== 1'b0) begin n_err++; $display("FAIL reset_drop got %0b want 0", drop); end
        arst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_basic();
        ready = 1'b1;
        sample(1, 0); sample(2, 0); sample(3, 0);
        n_vec++; if (sum_val !== 1'b0) begin n_err++; $display("FAIL basic_early got val=%0b want 0", sum_val); end
        sample(4, 0);
        n_vec++; if (sum_val !== 1'b1) begin n_err++; $display("FAIL basic_val got %0b want 1", sum_val); end
        n_vec++; if (sum !== 10 || len !== 4) begin n_err++; $display("FAIL basic_sum got sum=%0d len=%0d want 10/4", sum, len); end
        n_vec++; if (max !== (MAX_EN ? 8'd4 : 8'd0)) begin n_err++; $display("FAIL basic_max got %0d want %0d", max, MAX_EN ? 4 : 0); end
        tick();
        n_vec++; if (sum_val !== 1'b0) begin n_err++; $display("FAIL basic_once got val=%0b want 0", sum_val); end
    endtask

    task automatic test_back_to_back();
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample(128, 0);
            n_vec++; if (drop !== 1'b0) begin n_err++; $display("FAIL b2b_drop[%0d] got %0b want 0", i, drop); end
            n_vec++; if (sum_val !== ((i % 4) == 3)) begin n_err++; $display("FAIL b2b_val[%0d] got %0b want %0b", i, sum_val, (i % 4) == 3); end
            if ((i % 4) == 3) begin
                n_vec++; if (sum !== 512 || len !== 4) begin n_err++; $display("FAIL b2b_sum[%0d] got sum=%0d len=%0d want 512/4", i, sum, len); end
                n_vec++; if (max !== (MAX_EN ? 8'd128 : 8'd0)) begin n_err++; $display("FAIL b2b_max[%0d] got %0d want %0d", i, max, MAX_EN ? 128 : 0); end
            end
        end
        tick();
        n_vec++; if (sum_val !== 1'b0) begin n_err++; $display("FAIL b2b_end got val=%0b want 0", sum_val); end
    endtask

    task automatic test_drop();
        int vals [8] = '{1, 2, 3, 4, 5, 5, 5, 5};
        ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sample(vals[i], 0);
            if (i >= 3) begin
                n_vec++; if (sum_val !== 1'b1 || sum !== 10 || len !== 4) begin n_err++; $display("FAIL drop_hold[%0d] got val=%0b sum=%0d len=%0d want 1/10/4", i, sum_val, sum, len); end
            end
            n_vec++; if (drop !== (i == 7)) begin n_err++; $display("FAIL drop_pulse[%0d] got %0b want %0b", i, drop, i == 7); end
        end
        tick();
        n_vec++; if (drop !== 1'b0 || sum !== 10 || max !== (MAX_EN ? 8'd4 : 8'd0)) begin n_err++; $display("FAIL drop_after got drop=%0b sum=%0d max=%0d want 0/10/%0d", drop, sum, max, MAX_EN ? 4 : 0); end
        ready = 1'b1;
        tick();
        n_vec++; if (sum_val !== 1'b0) begin n_err++; $display("FAIL drop_drain got val=%0b want 0", sum_val); end
        tick();
        n_vec++; if (sum_val !== 1'b0) begin n_err++; $display("FAIL drop_nomore got val=%0b want 0", sum_val); end
    endtask

    task automatic test_flush();
        ready = 1'b1;
        sample(7, 0);
        sample(5, 1);
        n_vec++; if (sum_val !== 1'b1 || sum !== 12 || len !== 2) begin n_err++; $display("FAIL flush_res got val=%0b sum=%0d len=%0d want 1/12/2", sum_val, sum, len); end
        n_vec++; if (max !== (MAX_EN ? 8'd7 : 8'd0)) begin n_err++; $display("FAIL flush_max got %0d want %0d", max, MAX_EN ? 7 : 0); end
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        n_vec++; if (sum_val !== 1'b0 || drop !== 1'b0) begin n_err++; $display("FAIL flush_empty got val=%0b drop=%0b want 0/0", sum_val, drop); end
        // Next window must start fresh after the close.
        sample(9, 0); sample(9, 0); sample(9, 0); sample(9, 0);
        n_vec++; if (sum_val !== 1'b1 || sum !== 36 || len !== 4) begin n_err++; $display("FAIL flush_next got val=%0b sum=%0d len=%0d want 1/36/4", sum_val, sum, len); end
        tick();
    endtask

    task automatic test_simultaneous();
        ready = 1'b0;
        sample(1, 0); sample(1, 0); sample(1, 0); sample(1, 0);
        n_vec++; if (sum_val !== 1'b1 || sum !== 4) begin n_err++; $display("FAIL simul_first got val=%0b sum=%0d want 1/4", sum_val, sum); end
        sample(2, 0); sample(2, 0); sample(2, 0);
        ready = 1'b1;
        sample(3, 0);
        n_vec++; if (sum_val !== 1'b1 || sum !== 9 || len !== 4) begin n_err++; $display("FAIL simul_new got val=%0b sum=%0d len=%0d want 1/9/4", sum_val, sum, len); end
        n_vec++; if (max !== (MAX_EN ? 8'd3 : 8'd0) || drop !== 1'b0) begin n_err++; $display("FAIL simul_max_drop got max=%0d drop=%0b want %0d/0", max, drop, MAX_EN ? 3 : 0); end
        tick();
        n_vec++; if (sum_val !== 1'b0 || drop !== 1'b0) begin n_err++; $display("FAIL simul_drain got val=%0b drop=%0b want 0/0", sum_val, drop); end
    endtask

    task automatic test_reset_mid();
        ready = 1'b1;
        // Leave a visible result in the register so the reset has
        // something to clear.
        ready = 1'b0;
        sample(6, 0); sample(6, 0); sample(6, 0); sample(6, 0);
        sample(2, 0); sample(2, 0);
        #2;
        arst_n = 1'b0;
        #1;
        n_vec++; if (sum_val !== 1'b0 || sum !== '0 || len !== '0 || max !== '0 || drop !== 1'b0) begin n_err++; $display("FAIL rst_mid got val=%0b sum=%0d len=%0d max=%0d drop=%0b want all 0", sum_val, sum, len, max, drop); end
        tick();
        arst_n = 1'b1;
        ready = 1'b1;
        repeat (3) tick();
        sample(1, 0); sample(1, 0); sample(1, 0); sample(1, 0);
        n_vec++; if (sum_val !== 1'b1 || sum !== 4 || len !== 4) begin n_err++; $display("FAIL rst_after got val=%0b sum=%0d len=%0d want 1/4/4", sum_val, sum, len); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_drop();
        test_flush();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_popcount_window_accumulator
`default_nettype wire
